store_queue: RTL and testbench
==============================

# store_queue

Parametrised circular store queue sitting between dispatch, the store execute ports, the ROB retire stage and the D-cache write port. It allocates entries in program order and captures address/data from execute. It marks entries committed when the ROB retires them and drains committed entries to the D-cache through a valid/ready handshake. It also forwards data from older stores to in-flight loads, with byte-mask granularity and an explicit stall for unresolved or partial overlaps.

## Interface
- `N_WAY`, 2: dispatch, execute, retire and load channels per cycle.
- `N_SQ`, 8: entries; power of two, ≥ N_WAY.
- `XLEN`, 32: data width; `BYTES = XLEN/8`. Derived widths: `IW = $clog2(N_SQ)`, `PW = IW+1` (pointer with wrap bit), `CW = $clog2(N_WAY)+1`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `dis_num` in CW: stores dispatched this cycle.
- `dis_idx` out N_WAY×PW: pointer assigned to dispatch slot i (tail+i).
- `free_slots` out CW: min(free entries, N_WAY).
- `ex_valid` in N_WAY: execute write per channel.
- `ex_idx` in N_WAY×IW: target entry.
- `ex_addr` in N_WAY×32: byte address.
- `ex_data` in N_WAY×XLEN: store data, LSB-aligned.
- `ex_size` in N_WAY×2: 0 byte, 1 half, 2 word.
- `ret_num` in CW: stores retired by ROB this cycle.
- `squash` in 1: branch mispredict; drop all uncommitted entries.
- `mem_req_valid` out 1, `mem_req_addr` out 32 (word-aligned), `mem_req_data` out XLEN (lane-aligned), `mem_req_mask` out BYTES: D-cache write request.
- `mem_req_ready` in 1: D-cache accepts.
- `ld_valid` in N_WAY, `ld_addr` in N_WAY×32, `ld_size` in N_WAY×2: load probe.
- `ld_sq_tail` in N_WAY×PW: SQ tail captured at load dispatch; entries older than it are older than the load.
- `ld_fwd_hit` out N_WAY, `ld_fwd_data` out N_WAY×XLEN (LSB-aligned, zero-extended), `ld_stall` out N_WAY.
- `empty` out 1.

## Operation
- State: per entry `valid`, `addr_ok`, `committed`, word address, lane-aligned data, byte mask. Pointers `head` (drain), `cmt` (next to commit), `tail`, all PW bits. The wrap bit distinguishes full from empty.
- Mask: size 0 sets 1 bit, size 1 sets 2 bits, size 2 sets 4 bits, shifted by `addr[1:0]`. Misaligned accesses are illegal (assertion).
- Dispatch: when `dis_num` ≤ `free_slots`, entries tail..tail+dis_num-1 become valid with `addr_ok`=0, and tail advances by `dis_num`. Otherwise nothing is allocated (assertion).
- Execute: when `ex_valid[i]` is set and the entry is valid and uncommitted, write addr/data/mask and set `addr_ok`.
- Retire: mark entries cmt..cmt+ret_num-1 committed and advance `cmt`. `ret_num` must not exceed the number of resolved uncommitted entries (assertion).
- Drain: `mem_req_valid` = head entry valid ∧ committed. The request is held stable until `mem_req_ready`. On handshake, clear the entry and advance head by one.
- Squash: applied after this cycle's retire. Tail is set to the post-retire `cmt`, and every entry in [cmt, tail) is invalidated. Same-cycle dispatch and execute writes are ignored. Committed entries keep draining.
- Forwarding, per load: scan valid entries from ld_sq_tail-1 down to head, youngest first. The first entry that is unresolved, or whose word address matches and whose mask overlaps the load mask, decides the result:
  - unresolved → `ld_stall`;
  - overlap with full cover → `ld_fwd_hit` with the selected bytes;
  - partial cover → `ld_stall`.
  - No deciding entry → hit=0, stall=0 (read the cache).
- `empty` = (head == tail).

## Timing
- Reset values: all valid=0, head=cmt=tail=0, `mem_req_valid`=0, `empty`=1, `free_slots`=min(N_SQ,N_WAY), load outputs 0.
- `dis_idx`, `free_slots` and forwarding outputs are combinational from registered state. Writes made at edge n are visible to them from cycle n+1.
- A slot freed by drain is counted in `free_slots` only the following cycle (no bypass).
- Pointer arithmetic is modulo 2·N_SQ; slot index = ptr[IW-1:0]. A full queue (N_SQ valid) gives `free_slots`=0.
- Reset asserted mid-drain drops `mem_req_valid` immediately; pending entries are lost.

## Structure
- Package `sq_pkg`: `SQ_ENTRY` struct, size encoding constants, and the functions `size_to_mask` and `lane_align`.
- Sub-module `sq_fwd_scan`: combinational age-ordered scan for one load, instantiated N_WAY times.

## Test plan
- Reset, dispatch 2/cycle for 4 cycles (N_SQ=8) → `free_slots` 2,2,2,2,0; `empty`=0; dis_idx wraps 0..7.
- Store word 0xDEADBEEF @0x100, commit, `mem_req_ready` low 3 cycles → request held stable; on ready, mask=4'b1111 and head advances.
- Older byte store 0xAA @0x101, load byte @0x101 → hit, data 0x000000AA. Load word @0x100 → stall.
- Older store with unresolved address, load any address → stall. After ex write to 0x200, load @0x100 → no hit, no stall.
- 5 entries with 2 committed; squash with ret_num=1 → tail = head+3, younger entries dropped, committed three drain.
- Fill to 8, drain one while dis_num=1 → dispatch refused that cycle, accepted the next.

Source files
------------

// File: rtl/sq_pkg.sv
`default_nettype none
// ============================================================================
// Module : sq_pkg
// Brief  : Shared types and helpers for the store queue (entry layout, masks).
// Rev    : 1.0
// ============================================================================
package sq_pkg;

    localparam int SQ_XLEN  = 32;
    localparam int SQ_BYTES = SQ_XLEN / 8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic                valid;
        logic                addr_ok;
        logic                committed;
        logic [29:0]         waddr;
        logic [SQ_XLEN-1:0]  data;
        logic [SQ_BYTES-1:0] mask;
    } SQ_ENTRY;

    function automatic logic [SQ_BYTES-1:0] size_to_mask(input logic [1:0] size,
                                                         input logic [1:0] off);
        logic [SQ_BYTES-1:0] base;
        case (size)
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            SZ_WORD: base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << off;
    endfunction

    function automatic logic [SQ_XLEN-1:0] lane_align(input logic [SQ_XLEN-1:0] data,
                                                      input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return !off[0];
            SZ_WORD: return off == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sq_fwd_scan.sv
`default_nettype none
// ============================================================================
// Module : sq_fwd_scan
// Brief  : Youngest-first scan of older stores for one load probe.
// Rev    : 1.0
// ============================================================================
module sq_fwd_scan
    import sq_pkg::*;
#(
    parameter int N_SQ = 8,
    parameter int IW   = $clog2(N_SQ),
    parameter int PW   = IW + 1
) (
    input  SQ_ENTRY              entries [N_SQ],
    input  logic [PW-1:0]        head,
    input  logic                 ld_valid,
    input  logic [31:0]          ld_addr,
    input  logic [1:0]           ld_size,
    input  logic [PW-1:0]        ld_tail,
    output logic                 fwd_hit,
    output logic [SQ_XLEN-1:0]   fwd_data,
    output logic                 stall
);

    logic [PW-1:0]       span;
    logic [PW-1:0]       p;
    logic [SQ_BYTES-1:0] lmask;
    logic [SQ_XLEN-1:0]  sel;
    logic                done;

    always_comb begin
        lmask    = size_to_mask(ld_size, ld_addr[1:0]);
        span     = ld_tail - head;
        p        = '0;
        sel      = '0;
        done     = 1'b0;
        fwd_hit  = 1'b0;
        stall    = 1'b0;
        fwd_data = '0;
        // A span beyond N_SQ means the load's older stores have all drained.
        if (ld_valid && span <= PW'(N_SQ)) begin
            for (int k = 0; k < N_SQ; k++) begin
                p = ld_tail - PW'(k + 1);
                if (!done && PW'(k) < span && entries[p[IW-1:0]].valid) begin
                    if (!entries[p[IW-1:0]].addr_ok) begin
                        stall = 1'b1;
                        done  = 1'b1;
                    end else if (entries[p[IW-1:0]].waddr == ld_addr[31:2] &&
                                 (entries[p[IW-1:0]].mask & lmask) != '0) begin
                        done = 1'b1;
                        if ((lmask & ~entries[p[IW-1:0]].mask) == '0) begin
                            fwd_hit = 1'b1;
                            for (int b = 0; b < SQ_BYTES; b++) begin
                                if (lmask[b]) sel[8*b +: 8] = entries[p[IW-1:0]].data[8*b +: 8];
                            end
                            fwd_data = sel >> {ld_addr[1:0], 3'b000};
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
// Module : store_queue
// Brief  : Circular store queue: allocate, resolve, commit, drain, forward.
// Rev    : 1.0
// ============================================================================
module store_queue
    import sq_pkg::*;
#(
    parameter int N_WAY = 2,
    parameter int N_SQ  = 8,
    parameter int XLEN  = SQ_XLEN,
    parameter int BYTES = XLEN / 8,
    parameter int IW    = $clog2(N_SQ),
    parameter int PW    = IW + 1,
    parameter int CW    = $clog2(N_WAY) + 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CW-1:0]                  dis_num,
    output logic [N_WAY-1:0][PW-1:0]       dis_idx,
    output logic [CW-1:0]                  free_slots,
    input  logic [N_WAY-1:0]               ex_valid,
    input  logic [N_WAY-1:0][IW-1:0]       ex_idx,
    input  logic [N_WAY-1:0][31:0]         ex_addr,
    input  logic [N_WAY-1:0][XLEN-1:0]     ex_data,
    input  logic [N_WAY-1:0][1:0]          ex_size,
    input  logic [CW-1:0]                  ret_num,
    input  logic                           squash,
    output logic                           mem_req_valid,
    output logic [31:0]                    mem_req_addr,
    output logic [XLEN-1:0]                mem_req_data,
    output logic [BYTES-1:0]               mem_req_mask,
    input  logic                           mem_req_ready,
    input  logic [N_WAY-1:0]               ld_valid,
    input  logic [N_WAY-1:0][31:0]         ld_addr,
    input  logic [N_WAY-1:0][1:0]          ld_size,
    input  logic [N_WAY-1:0][PW-1:0]       ld_sq_tail,
    output logic [N_WAY-1:0]               ld_fwd_hit,
    output logic [N_WAY-1:0][XLEN-1:0]     ld_fwd_data,
    output logic [N_WAY-1:0]               ld_stall,
    output logic                           empty
);

    SQ_ENTRY       entries   [N_SQ];
    SQ_ENTRY       entries_n [N_SQ];
    SQ_ENTRY       head_e;
    logic [PW-1:0] head, cmt, tail;
    logic [PW-1:0] head_n, cmt_n, tail_n;
    logic [PW-1:0] count, free_cnt, ptr, rptr;
    logic [IW-1:0] off;
    logic          ret_ok;

    assign count      = tail - head;
    assign free_cnt   = PW'(N_SQ) - count;
    assign free_slots = (free_cnt >= PW'(N_WAY)) ? CW'(N_WAY) : CW'(free_cnt);
    assign empty      = (head == tail);

    assign head_e        = entries[head[IW-1:0]];
    assign mem_req_valid = head_e.valid && head_e.committed;
    assign mem_req_addr  = {head_e.waddr, 2'b00};
    assign mem_req_data  = head_e.data;
    assign mem_req_mask  = head_e.mask;

    always_comb begin
        entries_n = entries;
        head_n    = head;
        cmt_n     = cmt;
        tail_n    = tail;
        ptr       = '0;
        off       = '0;
        if (mem_req_valid && mem_req_ready) begin
            entries_n[head[IW-1:0]] = '0;
            head_n                  = head + PW'(1);
        end
        if (!squash) begin
            for (int i = 0; i < N_WAY; i++) begin
                if (ex_valid[i] && entries[ex_idx[i]].valid && !entries[ex_idx[i]].committed) begin
                    entries_n[ex_idx[i]].addr_ok = 1'b1;
                    entries_n[ex_idx[i]].waddr   = ex_addr[i][31:2];
                    entries_n[ex_idx[i]].data    = lane_align(ex_data[i], ex_addr[i][1:0]);
                    entries_n[ex_idx[i]].mask    = size_to_mask(ex_size[i], ex_addr[i][1:0]);
                end
            end
            // Over-sized dispatch groups are refused whole, never split.
            if (dis_num <= free_slots) begin
                for (int i = 0; i < N_WAY; i++) begin
                    if (CW'(i) < dis_num) begin
                        ptr                          = tail + PW'(i);
                        entries_n[ptr[IW-1:0]]       = '0;
                        entries_n[ptr[IW-1:0]].valid = 1'b1;
                    end
                end
                tail_n = tail + PW'(dis_num);
            end
        end
        for (int i = 0; i < N_WAY; i++) begin
            if (CW'(i) < ret_num) begin
                ptr                              = cmt + PW'(i);
                entries_n[ptr[IW-1:0]].committed = 1'b1;
            end
        end
        cmt_n = cmt + PW'(ret_num);
        // Squash sees this cycle's retire, so just-committed stores survive.
        if (squash) begin
            tail_n = cmt_n;
            for (int s = 0; s < N_SQ; s++) begin
                off = IW'(s) - cmt_n[IW-1:0];
                if (PW'(off) < PW'(tail - cmt_n)) entries_n[s] = '0;
            end
        end
    end

    always_comb begin
        ret_ok = 1'b1;
        rptr   = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (CW'(i) < ret_num) begin
                rptr = cmt + PW'(i);
                if (!(entries[rptr[IW-1:0]].valid && entries[rptr[IW-1:0]].addr_ok &&
                      !entries[rptr[IW-1:0]].committed)) ret_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < N_SQ; s++) entries[s] <= '0;
            head <= '0;
            cmt  <= '0;
            tail <= '0;
        end else begin
            for (int s = 0; s < N_SQ; s++) entries[s] <= entries_n[s];
            head <= head_n;
            cmt  <= cmt_n;
            tail <= tail_n;
        end
    end

    generate
        for (genvar w = 0; w < N_WAY; w++) begin : g_way
            assign dis_idx[w] = tail + PW'(w);

            sq_fwd_scan #(
                .N_SQ (N_SQ),
                .IW   (IW),
                .PW   (PW)
            ) u_scan (
                .entries  (entries),
                .head     (head),
                .ld_valid (ld_valid[w]),
                .ld_addr  (ld_addr[w]),
                .ld_size  (ld_size[w]),
                .ld_tail  (ld_sq_tail[w]),
                .fwd_hit  (ld_fwd_hit[w]),
                .fwd_data (ld_fwd_data[w]),
                .stall    (ld_stall[w])
            );

            a_ex_aligned : assert property (@(posedge clock) disable iff (reset)
                ex_valid[w] |-> is_aligned(ex_size[w], ex_addr[w][1:0]));
            a_ld_aligned : assert property (@(posedge clock) disable iff (reset)
                ld_valid[w] |-> is_aligned(ld_size[w], ld_addr[w][1:0]));
        end
    endgenerate

    a_retire_ok : assert property (@(posedge clock) disable iff (reset) ret_ok);

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_store_queue
// Brief  : Directed self-checking bench with a D-cache request scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_store_queue;

    localparam int N_WAY = 2;
    localparam int N_SQ  = 8;
    localparam int XLEN  = 32;
    localparam int BYTES = 4;
    localparam int IW    = 3;
    localparam int PW    = 4;
    localparam int CW    = 2;

    logic                       clock;
    logic                       reset;
    logic [CW-1:0]              dis_num;
    logic [N_WAY-1:0][PW-1:0]   dis_idx;
    logic [CW-1:0]              free_slots;
    logic [N_WAY-1:0]           ex_valid;
    logic [N_WAY-1:0][IW-1:0]   ex_idx;
    logic [N_WAY-1:0][31:0]     ex_addr;
    logic [N_WAY-1:0][XLEN-1:0] ex_data;
    logic [N_WAY-1:0][1:0]      ex_size;
    logic [CW-1:0]              ret_num;
    logic                       squash;
    logic                       mem_req_valid;
    logic [31:0]                mem_req_addr;
    logic [XLEN-1:0]            mem_req_data;
    logic [BYTES-1:0]           mem_req_mask;
    logic                       mem_req_ready;
    logic [N_WAY-1:0]           ld_valid;
    logic [N_WAY-1:0][31:0]     ld_addr;
    logic [N_WAY-1:0][1:0]      ld_size;
    logic [N_WAY-1:0][PW-1:0]   ld_sq_tail;
    logic [N_WAY-1:0]           ld_fwd_hit;
    logic [N_WAY-1:0][XLEN-1:0] ld_fwd_data;
    logic [N_WAY-1:0]           ld_stall;
    logic                       empty;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } req_t;

    req_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [PW-1:0] tp;

    store_queue #(.N_WAY(N_WAY), .N_SQ(N_SQ), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset), .dis_num(dis_num), .dis_idx(dis_idx),
        .free_slots(free_slots), .ex_valid(ex_valid), .ex_idx(ex_idx),
        .ex_addr(ex_addr), .ex_data(ex_data), .ex_size(ex_size),
        .ret_num(ret_num), .squash(squash), .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_mask(mem_req_mask), .mem_req_ready(mem_req_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .ld_sq_tail(ld_sq_tail), .ld_fwd_hit(ld_fwd_hit),
        .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall), .empty(empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic dispatch(input logic [CW-1:0] n);
        dis_num = n;
        step();
        dis_num = '0;
        tp      = tp + PW'(n);
    endtask

    task automatic exec(input int ch, input logic [PW-1:0] p, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz);
        ex_valid[ch] = 1'b1;
        ex_idx[ch]   = p[IW-1:0];
        ex_addr[ch]  = a;
        ex_data[ch]  = d;
        ex_size[ch]  = sz;
        step();
        ex_valid[ch] = 1'b0;
    endtask

    task automatic retire(input logic [CW-1:0] n);
        ret_num = n;
        step();
        ret_num = '0;
    endtask

    // Independent model of the expected cache write for a store.
    task automatic expect_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        req_t r;
        logic [3:0] m;
        m = (sz == 2'd0) ? 4'b0001 : (sz == 2'd1) ? 4'b0011 : 4'b1111;
        r.addr = {a[31:2], 2'b00};
        r.mask = m << a[1:0];
        r.data = d << (8 * a[1:0]);
        sbq.push_back(r);
    endtask

    task automatic compare_front(input string tag);
        req_t r;
        r = sbq.pop_front();
        check({tag, "_addr"}, mem_req_addr, r.addr);
        check({tag, "_data"}, mem_req_data, r.data);
        check({tag, "_mask"}, mem_req_mask, r.mask);
    endtask

    task automatic drain_all(input string tag);
        int budget;
        budget = 40;
        mem_req_ready = 1'b1;
        while (sbq.size() > 0 && budget > 0) begin
            if (mem_req_valid) compare_front(tag);
            step();
            budget--;
        end
        mem_req_ready = 1'b0;
        check({tag, "_timeout_left"}, sbq.size(), 0);
        check({tag, "_empty"}, empty, 1'b1);
    endtask

    task automatic probe(input string tag, input int ch, input logic [31:0] a,
                         input logic [1:0] sz, input logic [PW-1:0] t,
                         input logic eh, input logic es, input logic [31:0] ed);
        ld_valid[ch]   = 1'b1;
        ld_addr[ch]    = a;
        ld_size[ch]    = sz;
        ld_sq_tail[ch] = t;
        #1;
        check({tag, "_hit"}, ld_fwd_hit[ch], eh);
        check({tag, "_stall"}, ld_stall[ch], es);
        if (eh) check({tag, "_data"}, ld_fwd_data[ch], ed);
        ld_valid[ch] = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; dis_num = '0; ex_valid = '0; ex_idx = '0; ex_addr = '0;
        ex_data = '0; ex_size = '0; ret_num = '0; squash = 1'b0;
        mem_req_ready = 1'b0; ld_valid = '0; ld_addr = '0; ld_size = '0;
        ld_sq_tail = '0; tp = '0;
        step(); step();
        reset = 1'b0;
        step();

        check("rst_free", free_slots, 2);
        check("rst_empty", empty, 1'b1);
        check("rst_memv", mem_req_valid, 1'b0);
        check("rst_ldhit", ld_fwd_hit, '0);
        check("rst_ldstall", ld_stall, '0);

        // Fill the queue two per cycle.
        for (int k = 0; k < 4; k++) begin
            check("fill_free", free_slots, 2);
            check("fill_idx0", dis_idx[0], PW'(2 * k));
            check("fill_idx1", dis_idx[1], PW'(2 * k + 1));
            dispatch(2);
        end
        check("full_free", free_slots, 0);
        check("full_empty", empty, 1'b0);
        check("full_idx_wrap", dis_idx[0], 4'd8);

        for (int k = 0; k < 8; k++)
            exec(k % 2, PW'(k), (k == 0) ? 32'h100 : 32'h400 + 32'(4 * k),
                 (k == 0) ? 32'hDEADBEEF : 32'h1000 + 32'(k), 2'd2);
        for (int k = 0; k < 8; k++)
            expect_req((k == 0) ? 32'h100 : 32'h400 + 32'(4 * k),
                       (k == 0) ? 32'hDEADBEEF : 32'h1000 + 32'(k), 2'd2);
        for (int k = 0; k < 4; k++) retire(2);

        for (int c = 0; c < 3; c++) begin
            check("hold_valid", mem_req_valid, 1'b1);
            check("hold_addr", mem_req_addr, 32'h100);
            check("hold_data", mem_req_data, 32'hDEADBEEF);
            step();
        end
        drain_all("drain1");
        check("drain1_free", free_slots, 2);

        // Forwarding against an older byte store.
        check("fwd_idx", dis_idx[0], tp);
        dispatch(1);
        exec(1, 4'd8, 32'h101, 32'hAA, 2'd0);
        probe("byte_hit", 0, 32'h101, 2'd0, 4'd9, 1'b1, 1'b0, 32'h000000AA);
        probe("word_partial", 1, 32'h100, 2'd2, 4'd9, 1'b0, 1'b1, 32'h0);
        probe("other_word", 0, 32'h104, 2'd2, 4'd9, 1'b0, 1'b0, 32'h0);
        probe("younger_store", 1, 32'h101, 2'd0, 4'd8, 1'b0, 1'b0, 32'h0);
        dispatch(1);
        probe("unresolved", 0, 32'h300, 2'd2, 4'd10, 1'b0, 1'b1, 32'h0);
        exec(0, 4'd9, 32'h200, 32'h12345678, 2'd2);
        probe("no_overlap", 1, 32'h100, 2'd0, 4'd10, 1'b0, 1'b0, 32'h0);
        probe("word_hit", 0, 32'h200, 2'd2, 4'd10, 1'b1, 1'b0, 32'h12345678);
        probe("half_hit", 1, 32'h202, 2'd1, 4'd10, 1'b1, 1'b0, 32'h00001234);
        expect_req(32'h101, 32'hAA, 2'd0);
        expect_req(32'h200, 32'h12345678, 2'd2);
        retire(2);
        drain_all("drain2");

        // Squash with a same-cycle retire.
        dispatch(2); dispatch(2); dispatch(1);
        for (int k = 0; k < 5; k++)
            exec(k % 2, PW'(10 + k), 32'h500 + 32'(4 * k), 32'hA0 + 32'(k), 2'd2);
        for (int k = 0; k < 3; k++) expect_req(32'h500 + 32'(4 * k), 32'hA0 + 32'(k), 2'd2);
        retire(2);
        ret_num = 2'd1; squash = 1'b1; dis_num = 2'd1;
        step();
        ret_num = '0; squash = 1'b0; dis_num = '0;
        tp = 4'd13;
        check("sq_tail", dis_idx[0], 4'd13);
        check("sq_free", free_slots, 2);
        check("sq_empty", empty, 1'b0);
        probe("sq_kept", 0, 32'h508, 2'd2, 4'd15, 1'b1, 1'b0, 32'hA2);
        probe("sq_dropped", 1, 32'h50C, 2'd2, 4'd15, 1'b0, 1'b0, 32'h0);
        drain_all("drain3");

        // Full queue: drain one while dispatching one.
        for (int k = 0; k < 4; k++) dispatch(2);
        check("full2_free", free_slots, 0);
        for (int k = 0; k < 8; k++)
            exec(k % 2, PW'(13 + k), 32'h600 + 32'(4 * k), 32'hC000 + 32'(k), 2'd2);
        for (int k = 0; k < 8; k++) expect_req(32'h600 + 32'(4 * k), 32'hC000 + 32'(k), 2'd2);
        for (int k = 0; k < 4; k++) retire(2);
        check("full2_memv", mem_req_valid, 1'b1);
        compare_front("refuse_req");
        mem_req_ready = 1'b1; dis_num = 2'd1;
        step();
        mem_req_ready = 1'b0; dis_num = '0;
        check("refused_idx", dis_idx[0], tp);
        check("refused_free", free_slots, 1);
        dispatch(1);
        check("accept_idx", dis_idx[0], tp);
        check("accept_free", free_slots, 0);
        exec(0, 4'd5, 32'h700, 32'h77, 2'd2);
        expect_req(32'h700, 32'h77, 2'd2);
        retire(1);
        drain_all("drain4");

        // Asynchronous reset while a request is pending.
        dispatch(1);
        exec(1, 4'd6, 32'h800, 32'h88, 2'd2);
        retire(1);
        check("pre_rst_memv", mem_req_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_memv", mem_req_valid, 1'b0);
        check("async_rst_empty", empty, 1'b1);
        check("async_rst_idx", dis_idx[0], 4'd0);
        #2 reset = 1'b0;
        step();
        check("post_rst_free", free_slots, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
